// File: rtl/ce_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ce_gen_pkg
// Description : Shared types and defaults for the ce_gen clock-enable
//               generator: FSM state encoding, default parameter values and
//               the prescaler terminal-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ce_gen_pkg;

   // Run/stop control state
   typedef enum logic [0:0] {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int c_div_width_dflt   = 24;
   localparam int c_div_value_dflt   = 10;
   localparam int c_sync_stages_dflt = 2;

   // Last prescaler count before wrap (DIV_VALUE-1). Returned at 32 bits;
   // the caller casts to its DIV_WIDTH.
   function automatic logic [31:0] terminal_count(input int div_value);
      return 32'(div_value - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ce_gen_btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync_edge
// Description : Synchroniser plus rising-edge detector for one raw button.
//               edge_out is a registered one-cycle pulse, high SYNC_STAGES+1
//               cycles after the first clk edge that samples btn_in high.
//               A button already high when reset is released is ignored
//               until it has been seen low.
// Ports       : clk      - system clock
//               glob_rst - synchronous active-high reset
//               btn_in   - raw asynchronous button level
//               edge_out - one-cycle rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic glob_rst,
   input  logic btn_in,
   output logic edge_out
);

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("btn_sync_edge: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_lvl;    // retimed synchronised level
   logic                   r_prev;   // r_lvl one cycle earlier
   logic [SYNC_STAGES:0]   r_fill;   // marks when r_lvl holds a real post-reset sample
   logic                   r_armed;  // set once the button has been seen low
   logic                   r_edge;

   always_ff @(posedge clk) begin
      if (glob_rst) begin
         r_sync  <= '0;
         r_lvl   <= 1'b0;
         r_prev  <= 1'b0;
         r_fill  <= '0;
         r_armed <= 1'b0;
         r_edge  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
         r_lvl  <= r_sync[SYNC_STAGES-1];
         r_prev <= r_lvl;
         r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
         // The cleared flops after reset look like a low level; only a
         // genuinely sampled low arms the detector, so a button held
         // through reset does not produce a spurious edge.
         if (r_fill[SYNC_STAGES] && !r_lvl) begin
            r_armed <= 1'b1;
         end
         r_edge <= r_lvl & ~r_prev & r_armed;
      end
   end

   assign edge_out = r_edge;

endmodule
`default_nettype wire

// File: rtl/ce_gen.sv
`default_nettype none
// ============================================================================
// Module      : ce_gen
// Description : Clock-enable generator. Emits a one-cycle ce pulse every
//               DIV_VALUE clocks while running; run/stop toggles on each
//               run_btn press and step_btn issues a single ce while stopped.
//               Optional macro CE_GEN_AUTO_START_EN: reset enters RUN
//               instead of STOP.
// Ports       : clk      - system clock (rising edge)
//               glob_rst - synchronous active-high reset
//               run_btn  - raw button, toggles STOP/RUN
//               step_btn - raw button, single ce while in STOP
//               ce       - registered one-cycle enable pulse
//               running  - registered, high while in RUN
//               phase    - prescaler count 0..DIV_VALUE-1
// Revision    : 1.0 - initial release
// ============================================================================
module ce_gen
   import ce_gen_pkg::*;
#(
   parameter int DIV_WIDTH   = c_div_width_dflt,
   parameter int DIV_VALUE   = c_div_value_dflt,
   parameter int SYNC_STAGES = c_sync_stages_dflt
) (
   input  logic                 clk,
   input  logic                 glob_rst,
   input  logic                 run_btn,
   input  logic                 step_btn,
   output logic                 ce,
   output logic                 running,
   output logic [DIV_WIDTH-1:0] phase
);

   if (DIV_VALUE < 2 || longint'(DIV_VALUE) > (longint'(1) << DIV_WIDTH)) begin : g_bad_div
      $error("ce_gen: DIV_VALUE must be in 2..2**DIV_WIDTH");
   end

   localparam logic [DIV_WIDTH-1:0] c_tc = DIV_WIDTH'(terminal_count(DIV_VALUE));

`ifdef CE_GEN_AUTO_START_EN
   localparam state_t c_rst_state = ST_RUN;
`else
   localparam state_t c_rst_state = ST_STOP;
`endif

   logic w_run_edge;
   logic w_step_edge;

   btn_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_run_sync (
      .clk      (clk),
      .glob_rst (glob_rst),
      .btn_in   (run_btn),
      .edge_out (w_run_edge)
   );

   btn_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_step_sync (
      .clk      (clk),
      .glob_rst (glob_rst),
      .btn_in   (step_btn),
      .edge_out (w_step_edge)
   );

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DIV_WIDTH-1:0] r_phase;
   logic [DIV_WIDTH-1:0] w_phase_nxt;
   logic [DIV_WIDTH-1:0] w_phase_inc;
   logic                 r_ce;
   logic                 w_ce_nxt;
   logic                 r_running;

   always_ff @(posedge clk) begin
      if (glob_rst) begin
         r_state   <= c_rst_state;
         r_phase   <= '0;
         r_ce      <= 1'b0;
         r_running <= (c_rst_state == ST_RUN);
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_ce      <= w_ce_nxt;
         r_running <= (w_state_nxt == ST_RUN);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_ce_nxt    = 1'b0;
      // Modulo-DIV_VALUE increment: explicit wrap at the terminal count
      w_phase_inc = (r_phase == c_tc) ? '0 : r_phase + DIV_WIDTH'(1);

      unique case (r_state)
         ST_STOP: begin
            if (w_run_edge) begin
               // A simultaneous step is dropped: run wins
               w_state_nxt = ST_RUN;
               w_phase_nxt = '0;
            end else if (w_step_edge) begin
               w_ce_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            // Terminal ce is still issued when stopping on the same cycle
            w_ce_nxt    = (r_phase == c_tc);
            w_phase_nxt = w_phase_inc;
            if (w_run_edge) begin
               w_state_nxt = ST_STOP;
            end
         end
      endcase
   end

   assign ce      = r_ce;
   assign running = r_running;
   assign phase   = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_ce_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ce_gen
// Description : Self-checking bench for ce_gen with DIV_VALUE=4,
//               SYNC_STAGES=2. A behavioural model predicts ce, running and
//               phase every cycle; directed scenarios add literal checks on
//               latencies and pulse counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ce_gen;

   localparam int DIV = 4;
   localparam int S   = 2;
   localparam int W   = 24;
`ifdef CE_GEN_AUTO_START_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         glob_rst = 1'b1;
   logic         run_btn = 1'b0;
   logic         step_btn = 1'b0;
   logic         ce;
   logic         running;
   logic [W-1:0] phase;

   ce_gen #(
      .DIV_WIDTH   (W),
      .DIV_VALUE   (DIV),
      .SYNC_STAGES (S)
   ) dut (
      .clk      (clk),
      .glob_rst (glob_rst),
      .run_btn  (run_btn),
      .step_btn (step_btn),
      .ce       (ce),
      .running  (running),
      .phase    (phase)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ce_count = 0;
   int ce_q[$];
   int last_rise = -1000;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int first_ce_after(input int c);
      foreach (ce_q[i]) begin
         if (ce_q[i] >= c) return ce_q[i];
      end
      return -1000;
   endfunction

   // ---------------- behavioural model ----------------
   // A button press is a post-reset low sample followed by a high sample.
   // Its edge reaches the control decision S+2 clocks after the high sample.
   bit             m_valid = 1'b0;
   bit             m_run   = 1'b0;
   bit             m_ce    = 1'b0;
   int             m_phase = 0;
   logic [S+1:0]   run_pipe  = '0;
   logic [S+1:0]   step_pipe = '0;
   bit             have_prev = 1'b0;
   bit             prev_run  = 1'b0;
   bit             prev_step = 1'b0;
   logic           prev_running_obs = 1'b0;

   always @(posedge clk) begin
      bit re, se, nr, ns;
      if (glob_rst) begin
         m_run     = AUTO;
         m_phase   = 0;
         m_ce      = 1'b0;
         run_pipe  = '0;
         step_pipe = '0;
         have_prev = 1'b0;
         m_valid   = 1'b1;
         cyc       = 0;
      end else begin
         cyc++;
         re = run_pipe[S+1];
         se = step_pipe[S+1];
         nr = have_prev && !prev_run && run_btn;
         ns = have_prev && !prev_step && step_btn;
         run_pipe  = {run_pipe[S:0], nr};
         step_pipe = {step_pipe[S:0], ns};
         prev_run  = run_btn;
         prev_step = step_btn;
         have_prev = 1'b1;
         m_ce = m_run ? (m_phase == DIV - 1) : (se && !re);
         if (m_run) begin
            m_phase = (m_phase + 1) % DIV;
            if (re) m_run = 1'b0;
         end else if (re) begin
            m_run   = 1'b1;
            m_phase = 0;
         end
      end
      #1;
      if (m_valid) begin
         check("ce", 64'(ce), 64'(m_ce));
         check("running", 64'(running), 64'(m_run));
         check("phase", 64'(phase), 64'(m_phase));
      end
      if (ce === 1'b1) begin
         ce_count++;
         ce_q.push_back(cyc);
      end
      if (running === 1'b1 && prev_running_obs === 1'b0) last_rise = cyc;
      prev_running_obs = running;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_phase(input int v, input string name);
      int k = 0;
      while (phase !== W'(v) && k < 12) begin
         tick(1);
         k++;
      end
      check(name, 64'(phase), 64'(v));
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int p;
      int n0;
      int f;
      int ps[3];

      // 1. reset with buttons low
      glob_rst = 1'b1;
      tick(2);
      glob_rst = 1'b0;
      check("rst_ce", 64'(ce), 64'd0);
      check("rst_running", 64'(running), 64'(AUTO));
      check("rst_phase", 64'(phase), 64'd0);
`ifdef CE_GEN_AUTO_START_EN
      tick(6);
      check("auto_first_ce", 64'(first_ce_after(1)), 64'd4);
      run_btn = 1'b1;
      tick(2);
      run_btn = 1'b0;
      tick(8);
      check("auto_stopped", 64'(running), 64'd0);
`else
      tick(4);
`endif

      // 2. run press held for 10 cycles
      p = cyc + 1;
      run_btn = 1'b1;
      tick(10);
      run_btn = 1'b0;
      tick(12);
      check("s2_run_latency", 64'(last_rise - p), 64'd4);
      f = first_ce_after(p);
      check("s2_first_ce", 64'(f - last_rise), 64'd4);
      check("s2_ce_spacing", 64'(first_ce_after(f + 1) - f), 64'd4);
      check("s2_one_toggle", 64'(running), 64'd1);

      // 3. stop request coinciding with the terminal count
      wait_phase(3, "s3_phase_align");
      p = cyc + 1;
      run_btn = 1'b1;
      tick(2);
      run_btn = 1'b0;
      tick(3);
      check("s3_terminal_ce", 64'(ce), 64'd1);
      check("s3_stopped", 64'(running), 64'd0);
      check("s3_phase_frozen", 64'(phase), 64'd0);
      n0 = ce_count;
      tick(20);
      check("s3_no_more_ce", 64'(ce_count - n0), 64'd0);

      // 4. three single steps while stopped
      n0 = ce_count;
      for (int i = 0; i < 3; i++) begin
         ps[i] = cyc + 1;
         step_btn = 1'b1;
         tick(2);
         step_btn = 1'b0;
         tick(4);
      end
      tick(4);
      check("s4_step_count", 64'(ce_count - n0), 64'd3);
      for (int i = 0; i < 3; i++) begin
         check("s4_step_latency", 64'(first_ce_after(ps[i]) - ps[i]), 64'd4);
      end
      check("s4_phase_held", 64'(phase), 64'd0);

      // 5. run and step pressed together: run wins, step dropped
      p = cyc + 1;
      run_btn  = 1'b1;
      step_btn = 1'b1;
      tick(2);
      run_btn  = 1'b0;
      step_btn = 1'b0;
      tick(12);
      check("s5_run_latency", 64'(last_rise - p), 64'd4);
      check("s5_first_ce", 64'(first_ce_after(p) - last_rise), 64'd4);

      // 6. reset mid-run with run_btn held across reset release
      wait_phase(2, "s6_phase_align");
      glob_rst = 1'b1;
      run_btn  = 1'b1;
      tick(1);
      glob_rst = 1'b0;
      check("s6_rst_running", 64'(running), 64'(AUTO));
      check("s6_rst_phase", 64'(phase), 64'd0);
      check("s6_rst_ce", 64'(ce), 64'd0);
      tick(10);
      check("s6_held_no_edge", 64'(running), 64'(AUTO));
      run_btn = 1'b0;
      tick(4);
      run_btn = 1'b1;
      tick(2);
      run_btn = 1'b0;
      tick(4);
      check("s6_repress", 64'(running), 64'(!AUTO));
      tick(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
